// File: rtl/pe_seq.sv
// pe_seq: command/operand sequencer feeding the pe processing element.
// Takes LOAD / STREAM / REUSE commands plus a valid/ready operand stream
// and turns them into per-cycle pe controls (store, reuse, addr, finish).
// Every pe-facing signal comes straight from a flop. Any cycle without an
// accepted beat drives act=0, so the always-accumulating pe adds nothing.
module pe_seq #(
    parameter int IN_PRECISION = 16,
    parameter int REG_SIZE     = 4,
    parameter int LEN_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_PRECISION-1:0] in_act,
    input  logic [IN_PRECISION-1:0] in_wgt,
    output logic [IN_PRECISION-1:0] act,
    output logic [IN_PRECISION-1:0] wgt,
    output logic                    store,
    output logic                    reuse,
    output logic [REG_SIZE-1:0]     addr,
    output logic                    finish,
    output logic                    res_valid,
    output logic                    busy
);

    // Address 0 of the pe regfile is never written by the sequencer, so the
    // weight pointer cycles through 1 .. REG_SIZE-1.
    localparam logic [REG_SIZE-1:0] PTR_ONE  = {{(REG_SIZE-1){1'b0}}, 1'b1};
    localparam logic [REG_SIZE-1:0] PTR_LAST = REG_SIZE[REG_SIZE-1:0] - PTR_ONE;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_REUSE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_FIN,
        S_RES
    } state_t;

    state_t             state;
    logic               mode_reuse;
    logic [LEN_W-1:0]   rem;
    logic [REG_SIZE-1:0] ptr;
    logic               beat;

    // Advance the regfile pointer, skipping address 0 on wrap.
    function automatic logic [REG_SIZE-1:0] next_ptr(input logic [REG_SIZE-1:0] p);
        return (p == PTR_LAST) ? PTR_ONE : p + PTR_ONE;
    endfunction

    // Handshake decode from the registered state and remaining count.
    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        in_ready  = ((state == S_LOAD) || (state == S_MAC)) && (rem != '0);
        beat      = in_ready && in_valid;
    end

    // Sequencer FSM: state, counters and all registered pe-facing outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            mode_reuse <= 1'b0;
            rem        <= '0;
            ptr        <= PTR_ONE;
            act        <= '0;
            wgt        <= '0;
            store      <= 1'b0;
            reuse      <= 1'b0;
            addr       <= '0;
            finish     <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            // Bubble values unless a beat or phase step overrides them below.
            act       <= '0;
            wgt       <= '0;
            store     <= 1'b0;
            reuse     <= 1'b0;
            addr      <= '0;
            finish    <= 1'b0;
            res_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        rem        <= cmd_len;
                        ptr        <= PTR_ONE;
                        mode_reuse <= (cmd_op == OP_REUSE);
                        state      <= (cmd_op == OP_LOAD) ? S_LOAD : S_MAC;
                    end
                end

                S_LOAD: begin
                    if (beat) begin
                        store <= 1'b1;
                        addr  <= ptr;
                        wgt   <= in_wgt;
                        ptr   <= next_ptr(ptr);
                        rem   <= rem - 1'b1;
                    end else if (rem == '0) begin
                        state <= S_IDLE;
                    end
                end

                S_MAC: begin
                    if (beat) begin
                        act <= in_act;
                        rem <= rem - 1'b1;
                        if (mode_reuse) begin
                            reuse <= 1'b1;
                            addr  <= ptr;
                            ptr   <= next_ptr(ptr);
                        end else begin
                            wgt <= in_wgt;
                        end
                    end else if (rem == '0) begin
                        // The last term has already been presented to the pe,
                        // so finish cannot collide with a live term.
                        finish <= 1'b1;
                        state  <= S_FIN;
                    end
                end

                S_FIN: begin
                    res_valid <= 1'b1;
                    state     <= S_RES;
                end

                S_RES: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_seq.sv
// tb_pe_seq: directed bench for pe_seq with a stand-in pe model and a
// per-cycle expected-output timeline derived from the handshake rules.
module tb_pe_seq;

    localparam int IP = 16;
    localparam int RS = 4;
    localparam int LW = 8;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [LW-1:0] cmd_len;
    logic          in_valid;
    logic          in_ready;
    logic [IP-1:0] in_act;
    logic [IP-1:0] in_wgt;
    logic [IP-1:0] act;
    logic [IP-1:0] wgt;
    logic          store;
    logic          reuse;
    logic [RS-1:0] addr;
    logic          finish;
    logic          res_valid;
    logic          busy;

    pe_seq #(.IN_PRECISION(IP), .REG_SIZE(RS), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
        .act(act), .wgt(wgt), .store(store), .reuse(reuse), .addr(addr),
        .finish(finish), .res_valid(res_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in pe: regfile store, accumulate every cycle, dump and clear on finish.
    logic signed [15:0] rf [0:15];
    logic signed [47:0] acc;
    logic signed [47:0] pe_out;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            pe_out <= '0;
        end else if (finish) begin
            pe_out <= acc;
            acc    <= '0;
        end else if (store) begin
            rf[addr] <= $signed(wgt);
        end else begin
            acc <= acc + $signed(act) * (reuse ? rf[addr] : $signed(wgt));
        end
    end

    typedef struct packed {
        logic [15:0]        act;
        logic [15:0]        wgt;
        logic               store;
        logic               reuse;
        logic [3:0]         addr;
        logic               finish;
        logic               res_valid;
        logic               busy;
        logic               cmd_ready;
        logic               in_ready;
        logic               chk_res;
        logic signed [63:0] res;
    } exp_t;

    exp_t    exp_q [$];
    bit      chk_en;
    bit      keep_cmd;
    int      checks;
    int      failures;
    longint  last_res;

    logic signed [15:0] b_act [0:15];
    logic signed [15:0] b_wgt [0:15];
    int                 b_gap [0:15];
    logic signed [15:0] wref  [0:3];

    // One comparison per cycle against the expected timeline.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({act, wgt, store, reuse, addr, finish, res_valid, busy, cmd_ready, in_ready} !==
                {e.act, e.wgt, e.store, e.reuse, e.addr, e.finish, e.res_valid, e.busy, e.cmd_ready, e.in_ready}) begin
                failures++;
                $display("FAIL outputs t=%0t got act=%0d wgt=%0d st=%0b ru=%0b ad=%0d fi=%0b rv=%0b bz=%0b cr=%0b ir=%0b want act=%0d wgt=%0d st=%0b ru=%0b ad=%0d fi=%0b rv=%0b bz=%0b cr=%0b ir=%0b",
                         $time, act, wgt, store, reuse, addr, finish, res_valid, busy, cmd_ready, in_ready,
                         e.act, e.wgt, e.store, e.reuse, e.addr, e.finish, e.res_valid, e.busy, e.cmd_ready, e.in_ready);
            end
            if (e.chk_res) begin
                checks++;
                last_res = longint'(pe_out);
                if (longint'(pe_out) != e.res) begin
                    failures++;
                    $display("FAIL pe_out t=%0t got=%0d want=%0d", $time, pe_out, e.res);
                end
            end
        end
    end

    task automatic chk(input string nm, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    function automatic exp_t e_zero(input bit bz, input bit ir);
        exp_t e;
        e           = '0;
        e.busy      = bz;
        e.cmd_ready = !bz;
        e.in_ready  = ir;
        return e;
    endfunction

    // End the current cycle; e is what the DUT must show in the next one.
    task automatic tick(input exp_t e);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic garbage();
        in_valid = 1'b0;
        in_act   = 16'($urandom);
        in_wgt   = 16'($urandom);
    endtask

    // Issue one command and its beats; the expected timeline follows from
    // accept timing alone. lit is a hand-computed pe result.
    task automatic run_cmd(input logic [1:0] op, input int len, input longint lit);
        exp_t   e;
        longint dot;
        int     p;
        bit     is_load;
        bit     is_reuse;
        dot      = 0;
        is_load  = (op == 2'b00);
        is_reuse = (op == 2'b10);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len[LW-1:0];
        tick(e_zero(1'b1, len > 0));
        if (!keep_cmd) cmd_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < b_gap[i]; g++) begin
                garbage();
                tick(e_zero(1'b1, 1'b1));
            end
            in_valid = 1'b1;
            in_act   = b_act[i];
            in_wgt   = b_wgt[i];
            p        = 1 + (i % (RS - 1));
            e        = e_zero(1'b1, i < len - 1);
            if (is_load) begin
                e.store = 1'b1;
                e.addr  = 4'(p);
                e.wgt   = b_wgt[i];
                wref[p] = b_wgt[i];
            end else begin
                e.act = b_act[i];
                if (is_reuse) begin
                    e.reuse = 1'b1;
                    e.addr  = 4'(p);
                    dot    += longint'(b_act[i]) * longint'(wref[p]);
                end else begin
                    e.wgt = b_wgt[i];
                    dot  += longint'(b_act[i]) * longint'(b_wgt[i]);
                end
            end
            tick(e);
        end
        garbage();
        if (is_load) begin
            tick(e_zero(1'b0, 1'b0));
        end else begin
            e        = e_zero(1'b1, 1'b0);
            e.finish = 1'b1;
            tick(e);
            e           = e_zero(1'b1, 1'b0);
            e.res_valid = 1'b1;
            e.chk_res   = 1'b1;
            e.res       = dot;
            tick(e);
            tick(e_zero(1'b0, 1'b0));
            chk("pe_result_literal", last_res, lit);
        end
    endtask

    task automatic set_beats(input int n);
        for (int i = 0; i < 16; i++) begin
            b_gap[i] = 0;
            if (i >= n) begin
                b_act[i] = '0;
                b_wgt[i] = '0;
            end
        end
    endtask

    initial begin
        exp_t e;
        clk       = 1'b0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;
        in_valid  = 1'b0;
        in_act    = '0;
        in_wgt    = '0;
        chk_en    = 1'b1;
        keep_cmd  = 1'b0;
        checks    = 0;
        failures  = 0;
        last_res  = 0;
        for (int i = 0; i < 4; i++) wref[i] = '0;

        #2 rst = 1'b0;
        tick(e_zero(1'b0, 1'b0));
        tick(e_zero(1'b0, 1'b0));
        rst = 1'b1;
        tick(e_zero(1'b0, 1'b0));
        tick(e_zero(1'b0, 1'b0));

        // STREAM (2,3),(4,5),(1,7)
        set_beats(3);
        b_act[0] = 2; b_wgt[0] = 3;
        b_act[1] = 4; b_wgt[1] = 5;
        b_act[2] = 1; b_wgt[2] = 7;
        run_cmd(2'b01, 3, 33);

        // LOAD 10,20,30 then REUSE acts 1..5
        set_beats(3);
        b_wgt[0] = 10; b_wgt[1] = 20; b_wgt[2] = 30;
        b_act[0] = 99; b_act[1] = 98; b_act[2] = 97;
        run_cmd(2'b00, 3, 0);
        set_beats(5);
        for (int i = 0; i < 5; i++) begin
            b_act[i] = 16'(i + 1);
            b_wgt[i] = 16'(50 + i);
        end
        run_cmd(2'b10, 5, 280);

        // STREAM (3,3),(2,8) without and with a 3-cycle bubble
        set_beats(2);
        b_act[0] = 3; b_wgt[0] = 3;
        b_act[1] = 2; b_wgt[1] = 8;
        run_cmd(2'b01, 2, 25);
        b_gap[1] = 3;
        run_cmd(2'b01, 2, 25);

        // zero-length MAC and LOAD
        set_beats(0);
        run_cmd(2'b01, 0, 0);
        run_cmd(2'b00, 0, 0);

        // reserved op behaves as STREAM, signed operand
        set_beats(1);
        b_act[0] = -6; b_wgt[0] = 7;
        run_cmd(2'b11, 1, -42);

        // LOAD with pointer wrap (addr 1,2,3,1), then REUSE with a bubble
        set_beats(4);
        b_wgt[0] = 5; b_wgt[1] = 6; b_wgt[2] = 7; b_wgt[3] = 8;
        b_gap[2] = 2;
        run_cmd(2'b00, 4, 0);
        set_beats(3);
        b_act[0] = 1; b_act[1] = 1; b_act[2] = 1;
        b_gap[1] = 1;
        run_cmd(2'b10, 3, 21);

        // async reset after 2 of 4 STREAM beats
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_len   = 8'd4;
        tick(e_zero(1'b1, 1'b1));
        cmd_valid = 1'b0;
        in_valid  = 1'b1; in_act = 16'd2; in_wgt = 16'd2;
        e = e_zero(1'b1, 1'b1); e.act = 16'd2; e.wgt = 16'd2;
        tick(e);
        in_act = 16'd3; in_wgt = 16'd3;
        e = e_zero(1'b1, 1'b1); e.act = 16'd3; e.wgt = 16'd3;
        tick(e);
        in_valid = 1'b0;
        chk_en   = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_async_outputs", longint'({act, wgt, store, reuse, addr, finish, res_valid, busy}), 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_release_cmd_ready", longint'(cmd_ready), 1);
        chk("rst_release_pe_out", longint'(pe_out), 0);
        exp_q.delete();
        chk_en = 1'b1;
        tick(e_zero(1'b0, 1'b0));
        tick(e_zero(1'b0, 1'b0));
        tick(e_zero(1'b0, 1'b0));

        // cmd_valid held through two back-to-back STREAM len=1 commands
        keep_cmd = 1'b1;
        set_beats(1);
        b_act[0] = 3; b_wgt[0] = 4;
        run_cmd(2'b01, 1, 12);
        b_act[0] = 5; b_wgt[0] = -2;
        run_cmd(2'b01, 1, -10);
        cmd_valid = 1'b0;
        keep_cmd  = 1'b0;
        tick(e_zero(1'b0, 1'b0));
        tick(e_zero(1'b0, 1'b0));
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_seq.md
Name: pe_seq

Overview:
- Sequencer directly upstream of the pe processing element; drives every pe control and data input.
- Accepts load / dot-product commands and a valid/ready operand stream.
- Preloads weights into pe regfile addresses 1..REG_SIZE-1, then issues streamed or weight-reuse MAC terms.
- Issues finish after the last term and pulses res_valid when pe out holds the dot-product result.

Parameters:
IN_PRECISION, 16, width of act/wgt operands (matches pe)
REG_SIZE, 4, pe regfile depth; also pe addr width in bits; must be >= 2
LEN_W, 8, width of command term count

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when both high
cmd_op  input  2  00 LOAD, 01 STREAM, 10 REUSE, 11 reserved (treated as STREAM)
cmd_len  input  LEN_W  number of terms/weights, 0 allowed
in_valid  input  1  operand beat offered
in_ready  output  1  operand beat accepted when both high
in_act  input  IN_PRECISION  activation
in_wgt  input  IN_PRECISION  weight
act  output  IN_PRECISION  to pe act
wgt  output  IN_PRECISION  to pe wgt
store  output  1  to pe store
reuse  output  1  to pe reuse
addr  output  REG_SIZE  to pe addr
finish  output  1  to pe finish
res_valid  output  1  one-cycle pulse: pe out holds the result
busy  output  1  high whenever state != IDLE

Behaviour:
- All outputs registered. While rst low: act=0, wgt=0, store=0, reuse=0, addr=0, finish=0, res_valid=0, state=IDLE.
- rst assertion mid-command aborts immediately; no finish issued; the command is discarded.
- States: IDLE, LOAD, MAC, FIN, RES.
- cmd_ready = (state==IDLE).
- in_ready = (state is LOAD or MAC) and remaining count > 0.
- IDLE:
  - On accept, latch cmd_op and cmd_len into remaining count; set ptr=1.
  - Go to LOAD for op 00, MAC otherwise.
- LOAD:
  - Each accepted beat: next cycle store=1, addr=ptr, wgt=in_wgt, act=0, reuse=0.
  - ptr increments and wraps REG_SIZE-1 -> 1; remaining decrements.
  - When remaining==0, return to IDLE (no finish, no res_valid).
  - len=0: LOAD returns to IDLE the next cycle with no store.
- MAC:
  - Each accepted beat, next cycle store=0 and act=in_act.
  - STREAM: wgt=in_wgt, reuse=0.
  - REUSE: reuse=1, addr=ptr, wgt=0; ptr wraps as in LOAD.
  - When remaining==0, go to FIN; len=0 goes to FIN the next cycle.
- Bubble cycles (no accepted beat) in any state: act=0, wgt=0, store=0, reuse=0. The pe accumulates every cycle, so act=0 is mandatory.
- FIN: drive finish=1, act=0, reuse=0 for exactly one cycle, then go to RES.
  - finish is never coincident with a MAC term; pe clears its accumulator on finish, so a coincident term would be lost.
- RES: res_valid=1 for one cycle, then IDLE.
- Latency: last accepted beat at edge N -> finish high after edge N+1 -> res_valid high after edge N+2, coincident with the updated pe out.
- cmd_valid during busy is ignored (cmd_ready low) and held by the source.
- Next command is accepted in the first IDLE cycle after RES (or after LOAD completes).
- addr is 0 whenever not in a LOAD/REUSE beat cycle; store and reuse are never both high.

Test Plan:
- STREAM len=3, pairs (2,3),(4,5),(1,7) -> act/wgt appear one cycle after each accept, reuse=0; one finish pulse; res_valid 2 cycles after last accept; pe model out=33.
- LOAD len=3, wgts 10,20,30 -> store pulses at addr 1,2,3. Then REUSE len=5, acts 1..5 -> addr sequence 1,2,3,1,2; pe out=280 at res_valid.
- STREAM len=2 with in_valid low 3 cycles between beats -> act=0 and store=0 during bubbles; pe out unchanged versus no-bubble run (e.g. (3,3),(2,8) -> 25).
- MAC len=0 -> in_ready never high; finish next cycle, res_valid one cycle later, pe out=0. LOAD len=0 -> no store, busy for 1 cycle, back to IDLE.
- rst low mid-MAC after 2 of 4 beats -> all outputs 0 immediately (async); no finish, no res_valid; cmd_ready=1 in first cycle after release.
- cmd_valid held high continuously with two STREAM len=1 commands -> second accepted only in the cycle after first res_valid; two distinct res_valid pulses with correct results.
